fetch_instr_buffer: RTL

//  Fetch-side producer of the 32-bit instr word consumed by the control unit's decode path.

---
 rtl/fetch_instr_buffer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_instr_buffer.sv
// Fetch-side instruction buffer. It issues single-outstanding reads on the instruction bus,
// queues the fetched words, and presents the head entry to decode as a valid/ready stream.
// Redirect and ifence flush the queue and restart fetch at redirect_pc. Halt stops fetch
// until reset.
module fetch_instr_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  input  logic        decode_ready,
  input  logic        redirect,
  input  logic        ifence,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthW = DEPTH[AW:0];

  typedef enum logic [1:0] {StFetch, StDiscard, StFault, StHalted} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     tgt_q, tgt_d;              // restart pc held while draining a stale request
  logic            halt_pend_q, halt_pend_d;  // drain ends in HALTED instead of restarting
  logic            fault_pend_q, fault_pend_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic            fault_mem[DEPTH];

  logic            flush, pop_raw, space, ren_int, accept, pending;
  logic            push, pop, clear, push_fault, resolve;
  logic [31:0]     push_data, resolve_pc;

  assign flush   = redirect | ifence;
  assign pop_raw = (cnt_q != '0) & decode_ready;
  // A pop frees a slot in the same cycle, so a full queue can still request.
  assign space   = (cnt_q < DepthW) | pop_raw;

  // Bus request: combinational so a pop and a new request can share a cycle.
  always_comb begin
    ren_int = 1'b0;
    case (state_q)
      StFetch:   ren_int = space;
      StDiscard: ren_int = 1'b1;
      default:   ren_int = 1'b0;
    endcase
  end

  // Reset forces the request low immediately, even mid-stall.
  assign imem_ren  = ren_int & ~RST;
  assign imem_addr = addr_q;
  assign accept    = imem_ren & ~imem_busy;
  assign pending   = imem_ren & imem_busy;

  // Control next state: halt beats redirect/ifence, which beat accept and pop.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_d        = tgt_q;
    halt_pend_d  = halt_pend_q;
    fault_pend_d = fault_pend_q;
    clear        = 1'b0;
    push         = 1'b0;
    push_fault   = 1'b0;
    pop          = 1'b0;
    resolve      = 1'b0;
    resolve_pc   = redirect_pc;

    if (state_q != StHalted) begin
      if (halt) begin
        clear        = 1'b1;
        fault_pend_d = 1'b0;
        if (pending) begin
          state_d     = StDiscard;
          halt_pend_d = 1'b1;
        end else begin
          state_d = StHalted;
        end
      end else if (flush) begin
        clear        = 1'b1;
        fault_pend_d = 1'b0;
        if (pending) begin
          state_d = StDiscard;
          tgt_d   = redirect_pc;
        end else if (halt_pend_q) begin
          state_d = StHalted;
        end else begin
          resolve = 1'b1;
        end
      end else begin
        pop = pop_raw;
        case (state_q)
          StFetch: begin
            if (accept) begin
              push   = 1'b1;
              addr_d = addr_q + 32'd4;
            end
          end
          StDiscard: begin
            if (accept) begin
              if (halt_pend_q) begin
                state_d = StHalted;
              end else begin
                resolve    = 1'b1;
                resolve_pc = tgt_q;
              end
            end
          end
          StFault: begin
            if (fault_pend_q) begin
              push         = 1'b1;
              push_fault   = 1'b1;
              fault_pend_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    // Misaligned targets never reach the bus; they become a single fault entry.
    if (resolve) begin
      addr_d      = resolve_pc;
      halt_pend_d = 1'b0;
      if (resolve_pc[1:0] != 2'b00) begin
        state_d      = StFault;
        fault_pend_d = 1'b1;
      end else begin
        state_d = StFetch;
      end
    end
  end

  assign push_data = push_fault ? NOP_INSN : imem_rdata;

  // Queue pointer and occupancy update.
  always_comb begin
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Control and pointer state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StFetch;
      addr_q       <= RESET_PC;
      tgt_q        <= RESET_PC;
      halt_pend_q  <= 1'b0;
      fault_pend_q <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_q        <= tgt_d;
      halt_pend_q  <= halt_pend_d;
      fault_pend_q <= fault_pend_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
    end
  end

  // Queue storage; contents are only observed while the entry is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_q]  <= push_data;
      pc_mem[wr_q]    <= addr_q;
      fault_mem[wr_q] <= push_fault;
    end
  end

  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? data_mem[rd_q] : NOP_INSN;
  assign instr_pc    = instr_valid ? pc_mem[rd_q] : 32'd0;
  assign fetch_fault = instr_valid & fault_mem[rd_q];

endmodule
